bomb_launcher: RTL and testbench

//   Per-player bomb source: turns a fire button into a thrown bomb.

---
 rtl/game_pkg.sv | 25 ++
 rtl/bomb_timer.sv | 50 +++++
 rtl/bomb_launcher.sv | 164 ++++++++++++++++
 tb/tb_bomb_launcher.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: facing encoding, bomb FSM states and grid defaults
// used by both bomb_launcher and stunDetector.
package game_pkg;

  localparam int GRID_W_DEF  = 40;
  localparam int GRID_H_DEF  = 30;
  localparam int COORD_W_DEF = 6;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } bomb_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bomb_timer.sv
// Loadable cycle down-counter with a whole-seconds readout; shared by the
// fuse and cooldown phases of bomb_launcher.
module bomb_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_cycles,
  input  logic [3:0]       i_load_sec,
  input  logic             i_count,
  output logic             o_done,
  output logic [3:0]       o_sec_left
);

  localparam int TICK_W = $clog2(CLK_HZ + 1);
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(CLK_HZ);

  logic [CNT_W-1:0]  r_cnt;
  logic [TICK_W-1:0] r_tick;
  logic [3:0]        r_sec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= '0;
      r_sec  <= '0;
    end else if (i_load) begin
      r_cnt  <= i_load_cycles;
      r_tick <= TICK_LOAD;
      r_sec  <= i_load_sec;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
      // secLeft is a ceiling: it drops once a full second of cycles has elapsed
      if (r_tick <= TICK_W'(1)) begin
        r_tick <= TICK_LOAD;
        if (r_sec != 4'd0) r_sec <= r_sec - 4'd1;
      end else begin
        r_tick <= r_tick - 1'b1;
      end
    end
  end

  assign o_done     = (r_cnt <= CNT_W'(1));
  assign o_sec_left = r_sec;

endmodule

// File: rtl/bomb_launcher.sv
// Per-player bomb source: fire edge -> latched clamped target, fuse, one-cycle
// blast pulse, then a re-arm cooldown.
//
// state    | meaning
// IDLE     | waiting for a fire rise while not stunned; ready=1
// ARMED    | fuse running, bombActive=1, target frozen
// BLAST    | one cycle, bombExploded=1
// COOLDOWN | re-arm lockout, ready=0
module bomb_launcher
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int FUSE_SEC     = 3,
  parameter int COOLDOWN_SEC = 2,
  parameter int THROW_DIST   = 3,
  parameter int GRID_W       = GRID_W_DEF,
  parameter int GRID_H       = GRID_H_DEF,
  parameter int COORD_W      = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fire,
  input  logic [COORD_W-1:0] posX,
  input  logic [COORD_W-1:0] posY,
  input  logic [1:0]         dir,
  input  logic               stunned,
  output logic [COORD_W-1:0] bombPosX,
  output logic [COORD_W-1:0] bombPosY,
  output logic               bombActive,
  output logic               bombExploded,
  output logic               ready,
  output logic [3:0]         secLeft
);

  localparam int CNT_W = $clog2(CLK_HZ * max2(FUSE_SEC, COOLDOWN_SEC) + 1);
  localparam logic [CNT_W-1:0] FUSE_CYC = CNT_W'(FUSE_SEC * CLK_HZ);
  localparam logic [CNT_W-1:0] COOL_CYC = CNT_W'(COOLDOWN_SEC * CLK_HZ);
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] DIST  = SW'(THROW_DIST);
  localparam logic signed [SW-1:0] MAX_X = SW'(GRID_W - 1);
  localparam logic signed [SW-1:0] MAX_Y = SW'(GRID_H - 1);

  bomb_state_e r_state;
  logic r_fire_q;
  logic r_active;
  logic r_exploded;
  logic r_ready;
  logic [COORD_W-1:0] r_pos_x;
  logic [COORD_W-1:0] r_pos_y;

  logic w_rise;
  logic w_accept;
  logic w_load;
  logic w_count;
  logic w_done;
  logic [CNT_W-1:0] w_load_cycles;
  logic [3:0] w_load_sec;
  logic signed [SW-1:0] w_tx;
  logic signed [SW-1:0] w_ty;
  logic [COORD_W-1:0] w_cx;
  logic [COORD_W-1:0] w_cy;

  assign w_rise   = fire & ~r_fire_q;
  assign w_accept = (r_state == IDLE) & w_rise & ~stunned;

  // Target math is signed and two bits wider so off-grid results clamp cleanly
  always_comb begin
    w_tx = $signed({2'b00, posX});
    w_ty = $signed({2'b00, posY});
    case (dir)
      DIR_UP:    w_ty = w_ty - DIST;
      DIR_DOWN:  w_ty = w_ty + DIST;
      DIR_LEFT:  w_tx = w_tx - DIST;
      default:   w_tx = w_tx + DIST;
    endcase
    if (w_tx < 0)          w_cx = '0;
    else if (w_tx > MAX_X) w_cx = MAX_X[COORD_W-1:0];
    else                   w_cx = w_tx[COORD_W-1:0];
    if (w_ty < 0)          w_cy = '0;
    else if (w_ty > MAX_Y) w_cy = MAX_Y[COORD_W-1:0];
    else                   w_cy = w_ty[COORD_W-1:0];
  end

  always_comb begin
    w_load        = w_accept;
    w_load_cycles = FUSE_CYC;
    w_load_sec    = 4'(FUSE_SEC);
    if ((r_state == BLAST) && (COOLDOWN_SEC != 0)) begin
      w_load        = 1'b1;
      w_load_cycles = COOL_CYC;
      w_load_sec    = 4'd0;
    end
  end

  assign w_count = (r_state == ARMED) | (r_state == COOLDOWN);

  bomb_timer #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_load),
    .i_load_cycles (w_load_cycles),
    .i_load_sec    (w_load_sec),
    .i_count       (w_count),
    .o_done        (w_done),
    .o_sec_left    (secLeft)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fire_q   <= 1'b1;
      r_active   <= 1'b0;
      r_exploded <= 1'b0;
      r_ready    <= 1'b1;
      r_pos_x    <= '0;
      r_pos_y    <= '0;
    end else begin
      r_fire_q   <= fire;
      r_exploded <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= ARMED;
            r_pos_x  <= w_cx;
            r_pos_y  <= w_cy;
            r_active <= 1'b1;
            r_ready  <= 1'b0;
          end
        end
        ARMED: begin
          if (w_done) begin
            r_state    <= BLAST;
            r_active   <= 1'b0;
            r_exploded <= 1'b1;
          end
        end
        BLAST: begin
          if (COOLDOWN_SEC == 0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_state <= COOLDOWN;
          end
        end
        default: begin
          if (w_done) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bombPosX     = r_pos_x;
  assign bombPosY     = r_pos_y;
  assign bombActive   = r_active;
  assign bombExploded = r_exploded;
  assign ready        = r_ready;

endmodule

// File: tb/tb_bomb_launcher.sv
// Directed bench for bomb_launcher with a 4 Hz clock, 3 s fuse, 2 s cooldown.
module tb_bomb_launcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       fire;
  logic [5:0] posX;
  logic [5:0] posY;
  logic [1:0] dir;
  logic       stunned;
  logic [5:0] bombPosX;
  logic [5:0] bombPosY;
  logic       bombActive;
  logic       bombExploded;
  logic       ready;
  logic [3:0] secLeft;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bomb_launcher #(
    .CLK_HZ(4), .FUSE_SEC(3), .COOLDOWN_SEC(2), .THROW_DIST(3),
    .GRID_W(40), .GRID_H(30), .COORD_W(6)
  ) dut (
    .clk(clk), .reset(reset), .fire(fire), .posX(posX), .posY(posY),
    .dir(dir), .stunned(stunned), .bombPosX(bombPosX), .bombPosY(bombPosY),
    .bombActive(bombActive), .bombExploded(bombExploded), .ready(ready),
    .secLeft(secLeft)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready never returned high (ready=%b)", name, ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fire = 1'b1; posX = 6'd10; posY = 6'd10; dir = 2'd3; stunned = 1'b0;
    step(); step();
    checks++;
    if ({bombActive, bombExploded, ready, secLeft, bombPosX, bombPosY} !== {1'b0, 1'b0, 1'b1, 4'd0, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL reset_values: act=%b exp=%b rdy=%b sec=%0d pos=(%0d,%0d) need 0 0 1 0 (0,0)",
               bombActive, bombExploded, ready, secLeft, bombPosX, bombPosY);
    end
    reset = 1'b0;
    step(); step();
    checks++;
    if (bombActive !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL held_through_reset: act=%b rdy=%b need act=0 rdy=1", bombActive, ready);
    end
    fire = 1'b0;
    step();
  endtask

  task automatic test_main_cycle();
    logic [3:0] exp_sec;
    posX = 6'd10; posY = 6'd10; dir = 2'd3;
    fire = 1'b1;
    step();
    fire = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_sec = (i < 4) ? 4'd3 : (i < 8) ? 4'd2 : 4'd1;
      checks++;
      if (bombActive !== 1'b1 || bombExploded !== 1'b0 || ready !== 1'b0 || secLeft !== exp_sec
          || bombPosX !== 6'd13 || bombPosY !== 6'd10) begin
        errors++;
        $display("FAIL fuse_cycle_%0d: act=%b exp=%b rdy=%b sec=%0d pos=(%0d,%0d) need 1 0 0 %0d (13,10)",
                 i, bombActive, bombExploded, ready, secLeft, bombPosX, bombPosY, exp_sec);
      end
      step();
    end
    checks++;
    if (bombActive !== 1'b0 || bombExploded !== 1'b1 || ready !== 1'b0 || secLeft !== 4'd0
        || bombPosX !== 6'd13 || bombPosY !== 6'd10) begin
      errors++;
      $display("FAIL blast: act=%b exp=%b rdy=%b sec=%0d pos=(%0d,%0d) need 0 1 0 0 (13,10)",
               bombActive, bombExploded, ready, secLeft, bombPosX, bombPosY);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ready !== 1'b0 || bombExploded !== 1'b0 || bombActive !== 1'b0) begin
        errors++;
        $display("FAIL cooldown_cycle_%0d: rdy=%b exp=%b act=%b need 0 0 0", i, ready, bombExploded, bombActive);
      end
      step();
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_cooldown: rdy=%b need 1", ready);
    end
  endtask

  task automatic throw_check(input string name, input logic [5:0] x, input logic [5:0] y,
                             input logic [1:0] d, input logic [5:0] ex, input logic [5:0] ey);
    posX = x; posY = y; dir = d;
    fire = 1'b1;
    step();
    fire = 1'b0;
    checks++;
    if (bombActive !== 1'b1 || bombPosX !== ex || bombPosY !== ey) begin
      errors++;
      $display("FAIL %s: act=%b pos=(%0d,%0d) need act=1 pos=(%0d,%0d)", name, bombActive, bombPosX, bombPosY, ex, ey);
    end
    wait_ready(name);
  endtask

  task automatic test_clamp();
    throw_check("clamp_right", 6'd38, 6'd5, 2'd3, 6'd39, 6'd5);
    throw_check("clamp_up", 6'd1, 6'd0, 2'd0, 6'd1, 6'd0);
    throw_check("clamp_left", 6'd1, 6'd7, 2'd2, 6'd0, 6'd7);
    throw_check("clamp_down", 6'd4, 6'd28, 2'd1, 6'd4, 6'd29);
  endtask

  task automatic test_fire_held();
    int pulses = 0;
    posX = 6'd10; posY = 6'd10; dir = 2'd3;
    fire = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bombExploded === 1'b1) pulses++;
    end
    fire = 1'b0;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL fire_held: pulses=%0d need 1", pulses);
    end
    wait_ready("fire_held_ready");
  endtask

  task automatic test_stunned();
    posX = 6'd10; posY = 6'd10; dir = 2'd3;
    stunned = 1'b1;
    fire = 1'b1;
    step();
    fire = 1'b0;
    step(); step();
    checks++;
    if (bombActive !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL stunned_drop: act=%b rdy=%b need act=0 rdy=1", bombActive, ready);
    end
    stunned = 1'b0;
    step(); step();
    checks++;
    if (bombActive !== 1'b0) begin
      errors++;
      $display("FAIL stunned_not_queued: act=%b need 0", bombActive);
    end
  endtask

  task automatic test_second_rise();
    int pulses = 0;
    logic [5:0] bx = 6'd0;
    logic [5:0] by = 6'd0;
    posX = 6'd10; posY = 6'd10; dir = 2'd3;
    fire = 1'b1;
    step();
    fire = 1'b0;
    step(); step();
    posX = 6'd20; posY = 6'd20; dir = 2'd1;
    fire = 1'b1;
    step();
    fire = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bombExploded === 1'b1) begin
        pulses++;
        bx = bombPosX;
        by = bombPosY;
      end
    end
    checks++;
    if (pulses !== 1 || bx !== 6'd13 || by !== 6'd10) begin
      errors++;
      $display("FAIL second_rise: pulses=%0d blast_pos=(%0d,%0d) need 1 (13,10)", pulses, bx, by);
    end
    wait_ready("second_rise_ready");
  endtask

  task automatic test_reset_mid_fuse();
    int pulses = 0;
    posX = 6'd10; posY = 6'd10; dir = 2'd3;
    fire = 1'b1;
    step();
    fire = 1'b0;
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bombActive, bombExploded, ready, secLeft, bombPosX, bombPosY} !== {1'b0, 1'b0, 1'b1, 4'd0, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL reset_mid_fuse: act=%b exp=%b rdy=%b sec=%0d pos=(%0d,%0d) need 0 0 1 0 (0,0)",
               bombActive, bombExploded, ready, secLeft, bombPosX, bombPosY);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      if (bombExploded === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL no_blast_after_reset: pulses=%0d need 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    throw_check("back_to_back_a", 6'd20, 6'd15, 2'd0, 6'd20, 6'd12);
    throw_check("back_to_back_b", 6'd20, 6'd15, 2'd2, 6'd17, 6'd15);
  endtask

  initial begin
    test_reset();
    test_main_cycle();
    test_clamp();
    test_fire_held();
    test_stunned();
    test_second_rise();
    test_reset_mid_fuse();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
